// File: rtl/dht11_pkg.sv
// dht11_pkg: shared definitions for the DHT11 responder and its host reader.
// Contents: FSM state encoding, frame geometry, default bus timing in
// microseconds, and the frame checksum helper.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_LOW = 3'd1,
    WAIT_RESP = 3'd2,
    ACK_LOW   = 3'd3,
    ACK_HIGH  = 3'd4,
    BIT_LOW   = 3'd5,
    BIT_HIGH  = 3'd6,
    END_LOW   = 3'd7
  } state_t;

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned BIT_CNT_W  = 6;
  localparam int unsigned US_W       = 16;

  // Default timing, shared with the host reader
  localparam int unsigned DEF_CLKS_PER_US  = 50;
  localparam int unsigned DEF_START_MIN_US = 18000;
  localparam int unsigned DEF_RESP_WAIT_US = 30;
  localparam int unsigned DEF_ACK_LOW_US   = 80;
  localparam int unsigned DEF_ACK_HIGH_US  = 80;
  localparam int unsigned DEF_BIT_LOW_US   = 50;
  localparam int unsigned DEF_BIT0_HIGH_US = 26;
  localparam int unsigned DEF_BIT1_HIGH_US = 70;
  localparam int unsigned DEF_END_LOW_US   = 50;

  // Byte sum of the four data bytes, taken in 10 bits and truncated to 8
  function automatic logic [7:0] frame_checksum(input logic [7:0] a,
                                                input logic [7:0] b,
                                                input logic [7:0] c,
                                                input logic [7:0] d);
    logic [9:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return sum[7:0];
  endfunction

endpackage

// File: rtl/dht11_phase_timer.sv
// dht11_phase_timer: microsecond phase timer for the DHT11 responder.
// A prescaler divides clk down to 1 us ticks, and a saturating us counter
// counts them.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   restart    clears prescaler and us counter (asserted on state change)
//   target_us  phase length in us; 0 never expires
//   us_count   whole microseconds elapsed since the last restart
//   expire     high in the last clk cycle of a target_us-long phase
module dht11_phase_timer
  import dht11_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = DEF_CLKS_PER_US
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  input  logic [US_W-1:0] target_us,
  output logic [US_W-1:0] us_count,
  output logic            expire
);

  localparam int unsigned PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_US - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [US_W-1:0]  us_q, us_d;

  // Prescaler and saturating microsecond counter next-state
  always_comb begin
    pre_d = pre_q;
    us_d  = us_q;
    if (restart) begin
      pre_d = '0;
      us_d  = '0;
    end else if (pre_q == PRE_MAX) begin
      pre_d = '0;
      // Saturate so an endless host low never wraps back below the threshold
      if (us_q != {US_W{1'b1}}) begin
        us_d = us_q + 16'd1;
      end else begin
        us_d = us_q;
      end
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  // Timer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      us_q  <= '0;
    end else begin
      pre_q <= pre_d;
      us_q  <= us_d;
    end
  end

  assign us_count = us_q;
  // Cycle index N*CLKS_PER_US-1 is the last cycle of an N us phase
  assign expire = (target_us != '0) && (pre_q == PRE_MAX) &&
                  (us_q == (target_us - 16'd1));

endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulation (responder end of the one-wire bus).
// Waits for a long host low, then sends ACK and a 40-bit frame
// {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first, open drain.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   dht11           open-drain bus, pulled low when drive_low=1, else z
//   hum_int..temp_dec  data bytes, latched when a valid start pulse ends
//   drive_low       registered bus pull-down state
//   busy            high from WAIT_RESP entry until IDLE is re-entered
//   frame_done      one-cycle pulse as END_LOW completes
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int unsigned CLKS_PER_US  = DEF_CLKS_PER_US,
  parameter int unsigned START_MIN_US = DEF_START_MIN_US,
  parameter int unsigned RESP_WAIT_US = DEF_RESP_WAIT_US,
  parameter int unsigned ACK_LOW_US   = DEF_ACK_LOW_US,
  parameter int unsigned ACK_HIGH_US  = DEF_ACK_HIGH_US,
  parameter int unsigned BIT_LOW_US   = DEF_BIT_LOW_US,
  parameter int unsigned BIT0_HIGH_US = DEF_BIT0_HIGH_US,
  parameter int unsigned BIT1_HIGH_US = DEF_BIT1_HIGH_US,
  parameter int unsigned END_LOW_US   = DEF_END_LOW_US
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        dht11,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       drive_low,
  output logic       busy,
  output logic       frame_done
);

  state_t                 state_q, state_d;
  logic [2:0]             sync_q, sync_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   drive_low_q, drive_low_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;

  logic                   bus_s;
  logic                   fall_s;
  logic                   restart_s;
  logic                   expire_s;
  logic [US_W-1:0]        target_s;
  logic [US_W-1:0]        us_count_s;

  // sync_q[1] is the two-flop synchronised bus; sync_q[2] its previous value
  assign bus_s     = sync_q[1];
  assign fall_s    = sync_q[2] & ~sync_q[1];
  assign restart_s = (state_d != state_q);

  dht11_phase_timer #(
    .CLKS_PER_US (CLKS_PER_US)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart_s),
    .target_us (target_s),
    .us_count  (us_count_s),
    .expire    (expire_s)
  );

  // Synchroniser shift
  always_comb begin
    sync_d = {sync_q[1:0], dht11};
  end

  // Length of the current timed phase
  always_comb begin
    target_s = '0;
    case (state_q)
      WAIT_RESP: target_s = US_W'(RESP_WAIT_US);
      ACK_LOW:   target_s = US_W'(ACK_LOW_US);
      ACK_HIGH:  target_s = US_W'(ACK_HIGH_US);
      BIT_LOW:   target_s = US_W'(BIT_LOW_US);
      BIT_HIGH: begin
        if (shift_q[FRAME_BITS-1]) begin
          target_s = US_W'(BIT1_HIGH_US);
        end else begin
          target_s = US_W'(BIT0_HIGH_US);
        end
      end
      END_LOW:   target_s = US_W'(END_LOW_US);
      default:   target_s = '0;
    endcase
  end

  // Next-state, frame shifter and registered-output next values
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_s) begin
          state_d = START_LOW;
        end else begin
          state_d = IDLE;
        end
      end
      START_LOW: begin
        // Still low: keep counting; a rise decides between start and glitch
        if (!bus_s) begin
          state_d = START_LOW;
        end else if (us_count_s >= US_W'(START_MIN_US)) begin
          state_d   = WAIT_RESP;
          shift_d   = {hum_int, hum_dec, temp_int, temp_dec,
                       frame_checksum(hum_int, hum_dec, temp_int, temp_dec)};
          bit_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RESP: begin
        if (expire_s) state_d = ACK_LOW;
        else          state_d = WAIT_RESP;
      end
      ACK_LOW: begin
        if (expire_s) state_d = ACK_HIGH;
        else          state_d = ACK_LOW;
      end
      ACK_HIGH: begin
        if (expire_s) begin
          state_d   = BIT_LOW;
          bit_cnt_d = '0;
        end else begin
          state_d = ACK_HIGH;
        end
      end
      BIT_LOW: begin
        if (expire_s) state_d = BIT_HIGH;
        else          state_d = BIT_LOW;
      end
      BIT_HIGH: begin
        if (expire_s) begin
          shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
            state_d = END_LOW;
          end else begin
            state_d = BIT_LOW;
          end
        end else begin
          state_d = BIT_HIGH;
        end
      end
      END_LOW: begin
        if (expire_s) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          state_d = END_LOW;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered so they change on entry
    drive_low_d = (state_d == ACK_LOW) || (state_d == BIT_LOW) ||
                  (state_d == END_LOW);
    busy_d      = (state_d != IDLE) && (state_d != START_LOW);
  end

  // State, data and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= 3'b111;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      drive_low_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      drive_low_q  <= drive_low_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Open drain: only ever pull low; the pull-up supplies the high level
  assign dht11      = drive_low_q ? 1'b0 : 1'bz;
  assign drive_low  = drive_low_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
